quad_1to2_demux: RTL and testbench
==================================

// Module: quad_1to2_demux
// PURPOSE
//  Write-side counterpart of the 4-bit 2-to-1 mux: steers one incoming data word to one of two
//  destination channels, chosen per word by dst. Each channel has a one-word holding register
//  with a valid/ready handshake. Sits between a producer (ALU/result bus) and two write-back consumers.
// PARAMETERS
//  WIDTH   4   data word width (bits)
//  CNT_W   8   width of per-channel accepted-word counters (only with QUAD_DEMUX_CNT_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       producer has a word on datain
//  in_ready   out  1       word on datain is accepted this cycle if in_valid
//  dst        in   1       destination select: 0 -> channel 0, 1 -> channel 1 (qualified by in_valid)
//  datain     in   WIDTH   input word
//  out0_valid out  1       channel 0 holds a word
//  out0_ready in   1       channel 0 consumer takes the word this cycle
//  out0_data  out  WIDTH   channel 0 word
//  out1_valid out  1       channel 1 holds a word
//  out1_ready in   1       channel 1 consumer takes the word this cycle
//  out1_data  out  WIDTH   channel 1 word
//  cnt0       out  CNT_W   words accepted for channel 0 (QUAD_DEMUX_CNT_EN only)
//  cnt1       out  CNT_W   words accepted for channel 1 (QUAD_DEMUX_CNT_EN only)
// BEHAVIOUR
//  - Reset (sync, active-high, sampled on clk rise): outN_valid=0, outN_data=0, cnt0=cnt1=0.
//    Reset mid-transfer discards held words; a word offered in the reset cycle is not accepted.
//  - Per-channel FSM, N in {0,1}: EMPTY (outN_valid=0) / FULL (outN_valid=1).
//    EMPTY --load--> FULL; FULL --drain, no load--> EMPTY; FULL --drain+load--> FULL (new word);
//    FULL --no drain--> FULL, outN_data held stable. drain = outN_valid & outN_ready.
//  - in_ready = ~outD_valid | outD_ready, D = dst (combinational from dst, outD_valid, outD_ready).
//    in_ready is low during reset.
//  - load for channel D = in_valid & in_ready & (dst==D); datain registered into outD_data.
//  - Latency: accepted word appears on outD_data with outD_valid=1 the cycle after acceptance.
//  - Throughput: one word/cycle per channel when its consumer holds ready high (drain+load same edge).
//  - Channels independent: a stalled channel never blocks words destined for the other channel;
//    the producer must hold in_valid/dst/datain stable until accepted.
//  - outN_ready while outN_valid=0 has no effect. Words never dropped or duplicated.
//  - Order preserved within each channel; no ordering relation between channels.
// CONFIGURATION
//  QUAD_DEMUX_CNT_EN defined: cnt0/cnt1 ports present; cntD increments by 1 on each load to
//    channel D; wraps 2^CNT_W-1 -> 0; reset to 0.
//  QUAD_DEMUX_CNT_EN undefined: cnt0/cnt1 ports and counter logic absent; all else identical.
// TESTING
//  1 reset=1 with out0/out1 FULL -> next cycle out0_valid=out1_valid=0, data=0, cnt0=cnt1=0.
//  2 in_valid=1,dst=0,datain=4'hA, out0 EMPTY -> in_ready=1; next cycle out0_valid=1,
//    out0_data=4'hA, out1_valid=0.
//  3 out1 FULL with 4'h3, out1_ready=0; offer dst=1,4'h5 -> in_ready=0, out1_data stays 4'h3;
//    raise out1_ready -> same-edge drain+load, next cycle out1_data=4'h5, out1_valid=1.
//  4 out0 FULL & stalled; offer dst=1,4'h7 -> accepted, out1_data=4'h7; out0_data unchanged.
//  5 both consumers ready, alternate dst 0/1 for 8 cycles, data 0..7 -> out0 sees 0,2,4,6 and
//    out1 sees 1,3,5,7, each 1 cycle after acceptance, no stall cycles.
//  6 QUAD_DEMUX_CNT_EN, CNT_W=2: 5 loads to channel 0 -> cnt0 = 1,2,3,0,1; cnt1 stays 0.

Source files
------------

// File: rtl/quad_1to2_demux.sv
// One-word-per-channel 1-to-2 demultiplexer: steers each accepted word to channel 0 or 1 by dst.
// Optional per-channel accepted-word counters are enabled with `define QUAD_DEMUX_CNT_EN.
module quad_1to2_demux #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             dst,
    input  logic [WIDTH-1:0] datain,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef QUAD_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    // Handshake: a word moves across an interface on a rising edge where valid and ready are both
    // high; valid never depends on ready, and a held word stays unchanged until it moves.

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("quad_1to2_demux: WIDTH and CNT_W must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    // Both channel FSMs live in one struct so a checker can bind to a single signal.
    typedef struct packed {
        chan_state_t ch1;
        chan_state_t ch0;
    } chan_states_t;

    chan_states_t state_q;
    chan_states_t state_d;
    logic         load0;
    logic         load1;
    logic         drain0;
    logic         drain1;

    assign out0_valid = (state_q.ch0 == FULL);
    assign out1_valid = (state_q.ch1 == FULL);

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = dst ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);
        end
        load0  = in_valid & in_ready & ~dst;
        load1  = in_valid & in_ready & dst;
        drain0 = out0_valid & out0_ready;
        drain1 = out1_valid & out1_ready;

        state_d = state_q;
        case (state_q.ch0)
            EMPTY:   if (load0) state_d.ch0 = FULL;
            FULL:    if (drain0 && !load0) state_d.ch0 = EMPTY;
            default: state_d.ch0 = EMPTY;
        endcase
        case (state_q.ch1)
            EMPTY:   if (load1) state_d.ch1 = FULL;
            FULL:    if (drain1 && !load1) state_d.ch1 = EMPTY;
            default: state_d.ch1 = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= '{ch1: EMPTY, ch0: EMPTY};
            out0_data <= '0;
            out1_data <= '0;
        end else begin
            state_q <= state_d;
            if (load0) out0_data <= datain;
            if (load1) out1_data <= datain;
        end
    end

`ifdef QUAD_DEMUX_CNT_EN
    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (load0) cnt0 <= cnt0 + 1'b1;
            if (load1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_quad_1to2_demux.sv
// Bench for quad_1to2_demux: directed scenarios plus random traffic against per-channel word queues.
// Counter checks are compiled in when QUAD_DEMUX_CNT_EN is defined.
module tb_quad_1to2_demux;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             dst;
    logic [WIDTH-1:0] datain;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
`ifdef QUAD_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

    quad_1to2_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dst        (dst),
        .datain     (datain),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef QUAD_DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    logic [1:0]       acc_flag;
    int               acc_cnt0;
    int               acc_cnt1;
    int               checks;
    int               errors;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Acceptance recorder: a word offered with in_ready high at mid-cycle moves on the next edge.
    always @(negedge clk) begin
        acc_flag = 2'b00;
        if (reset) begin
            check("in_ready_low_in_reset", {31'b0, in_ready}, 32'd0);
            exp_q0.delete();
            exp_q1.delete();
            acc_cnt0 = 0;
            acc_cnt1 = 0;
        end else if (in_valid && in_ready) begin
            if (dst) begin
                exp_q1.push_back(datain);
                acc_flag[1] = 1'b1;
                acc_cnt1++;
            end else begin
                exp_q0.push_back(datain);
                acc_flag[0] = 1'b1;
                acc_cnt0++;
            end
        end
    end

    // Monitor: words already registered are those queued before this cycle's acceptance.
    always @(negedge clk) begin
        int held0;
        int held1;
        #1;
        if (!reset) begin
            held0 = exp_q0.size() - int'(acc_flag[0]);
            held1 = exp_q1.size() - int'(acc_flag[1]);
            check("out0_valid", {31'b0, out0_valid}, {31'b0, held0 > 0});
            if (out0_valid && held0 > 0) begin
                check("out0_data", {28'b0, out0_data}, {28'b0, exp_q0[0]});
                if (out0_ready) void'(exp_q0.pop_front());
            end
            check("out1_valid", {31'b0, out1_valid}, {31'b0, held1 > 0});
            if (out1_valid && held1 > 0) begin
                check("out1_data", {28'b0, out1_data}, {28'b0, exp_q1[0]});
                if (out1_ready) void'(exp_q1.pop_front());
            end
`ifdef QUAD_DEMUX_CNT_EN
            check("cnt0", {30'b0, cnt0}, (acc_cnt0 - int'(acc_flag[0])) % (1 << CNT_W));
            check("cnt1", {30'b0, cnt1}, (acc_cnt1 - int'(acc_flag[1])) % (1 << CNT_W));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // Offer one word and hold it until accepted (bounded), then drop in_valid.
    task automatic send(input logic d, input logic [WIDTH-1:0] data);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        dst      = d;
        datain   = data;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            if (!got) cycle();
        end
        check("send_accepted", {31'b0, got}, 32'd1);
        cycle();
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp6[5];
        exp6 = '{1, 2, 3, 0, 1};
        checks     = 0;
        errors     = 0;
        acc_flag   = 2'b00;
        acc_cnt0   = 0;
        acc_cnt1   = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        dst        = 1'b0;
        datain     = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;

        // Both channels full, then reset with a word offered in the reset cycle.
        send(1'b0, 4'h9);
        send(1'b1, 4'h6);
        check("t1_full0", {31'b0, out0_valid}, 32'd1);
        check("t1_full1", {31'b0, out1_valid}, 32'd1);
        in_valid = 1'b1;
        dst      = 1'b0;
        datain   = 4'hF;
        do_reset();
        in_valid = 1'b0;
        #1;
        check("t1_valid0", {31'b0, out0_valid}, 32'd0);
        check("t1_valid1", {31'b0, out1_valid}, 32'd0);
        check("t1_data0", {28'b0, out0_data}, 32'd0);
        check("t1_data1", {28'b0, out1_data}, 32'd0);
`ifdef QUAD_DEMUX_CNT_EN
        check("t1_cnt0", {30'b0, cnt0}, 32'd0);
        check("t1_cnt1", {30'b0, cnt1}, 32'd0);
`endif

        // Single word to an empty channel 0.
        in_valid = 1'b1;
        dst      = 1'b0;
        datain   = 4'hA;
        #1;
        check("t2_in_ready", {31'b0, in_ready}, 32'd1);
        send(1'b0, 4'hA);
        check("t2_valid0", {31'b0, out0_valid}, 32'd1);
        check("t2_data0", {28'b0, out0_data}, 32'hA);
        check("t2_valid1", {31'b0, out1_valid}, 32'd0);

        // Stalled channel 1 back-pressures, then drains and reloads on the same edge.
        send(1'b1, 4'h3);
        in_valid = 1'b1;
        dst      = 1'b1;
        datain   = 4'h5;
        #1;
        check("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
        cycle();
        check("t3_data1_held", {28'b0, out1_data}, 32'h3);
        out1_ready = 1'b1;
        #1;
        check("t3_in_ready_high", {31'b0, in_ready}, 32'd1);
        cycle();
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        check("t3_valid1", {31'b0, out1_valid}, 32'd1);
        check("t3_data1_new", {28'b0, out1_data}, 32'h5);

        // Channel 0 stays stalled while channel 1 takes a word.
        out1_ready = 1'b1;
        cycle();
        out1_ready = 1'b0;
        send(1'b1, 4'h7);
        check("t4_data1", {28'b0, out1_data}, 32'h7);
        check("t4_data0_unchanged", {28'b0, out0_data}, 32'hA);
        check("t4_valid0", {31'b0, out0_valid}, 32'd1);

        // Full-rate alternating traffic with both consumers ready.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            dst      = 1'(i % 2);
            datain   = WIDTH'(i);
            cycle();
            check("t5_no_stall", {31'b0, acc_flag[i % 2]}, 32'd1);
        end
        in_valid = 1'b0;
        repeat (2) cycle();

`ifdef QUAD_DEMUX_CNT_EN
        // Counter wrap on channel 0.
        do_reset();
        out0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, WIDTH'(i));
            check("t6_cnt0", {30'b0, cnt0}, exp6[i]);
            check("t6_cnt1", {30'b0, cnt1}, 32'd0);
        end
`else
        exp6[0] = 0;
`endif

        // Random traffic with random back-pressure on each channel.
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid || acc_flag != 2'b00) begin
                in_valid = ($urandom_range(0, 3) != 0);
                dst      = 1'($urandom_range(0, 1));
                datain   = WIDTH'($urandom_range(0, 15));
            end
            cycle();
        end

        // Drain everything and confirm no word was lost.
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (4) cycle();
        check("final_q0_empty", exp_q0.size(), 32'd0);
        check("final_q1_empty", exp_q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
